// File: rtl/spi_rx_frame_decoder_if.sv
// Frame-decoder bus: raw SPI chip select and receive buffer in, decoded commands out.
// The master modport is the SPI receiver side; the slave modport is the decoder.
interface spi_rx_frame_decoder_if;
  logic               SPI_SSEL;
  logic [95:0]        rx_data;
  logic               frame_valid;
  logic signed [31:0] jointFreqCmd0;
  logic [15:0]        setPoint0;
  logic               jointEnable0;
  logic               DOUT0;
  logic               watchdog_timeout;
  logic [7:0]         error_count;

  modport master (
    output SPI_SSEL, rx_data,
    input  frame_valid, jointFreqCmd0, setPoint0, jointEnable0, DOUT0,
           watchdog_timeout, error_count
  );

  modport slave (
    input  SPI_SSEL, rx_data,
    output frame_valid, jointFreqCmd0, setPoint0, jointEnable0, DOUT0,
           watchdog_timeout, error_count
  );
endinterface

// File: rtl/spi_rx_frame_decoder.sv
// Decodes 96-bit SPI frames after chip-select release into joint/vout/dout commands,
// with a no-frame watchdog. Define SPI_RX_ERRCNT_EN to build the rejected-frame counter.
module spi_rx_frame_decoder #(
  parameter logic [31:0] RX_HEADER       = 32'h74697277,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_rx_frame_decoder_if.slave bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t r_state;

  logic       r_ssel_m;
  logic       r_ssel_s;
  logic       r_ssel_d;
  logic [2:0] r_sync_vld;
  logic       r_fall;
  logic       r_rise;

  // Edges are qualified until the pipeline holds only real pin samples, so the
  // reset value of 1 never fakes a fall on a transfer already in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ssel_m   <= 1'b1;
      r_ssel_s   <= 1'b1;
      r_ssel_d   <= 1'b1;
      r_sync_vld <= 3'b000;
      r_fall     <= 1'b0;
      r_rise     <= 1'b0;
    end else begin
      r_ssel_m   <= bus.SPI_SSEL;
      r_ssel_s   <= r_ssel_m;
      r_ssel_d   <= r_ssel_s;
      r_sync_vld <= {r_sync_vld[1:0], 1'b1};
      r_fall     <= r_sync_vld[2] & r_ssel_d & ~r_ssel_s;
      r_rise     <= r_sync_vld[2] & ~r_ssel_d & r_ssel_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (r_fall) r_state <= ST_XFER;
        ST_XFER:   if (r_rise) r_state <= ST_SETTLE;
        ST_SETTLE: r_state <= ST_CHECK;
        ST_CHECK:  r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

  // Fields arrive on the wire least-significant byte first.
  logic [31:0] w_header;
  logic [31:0] w_freq;
  logic [15:0] w_setpoint;
  logic        w_commit;
  logic        w_unused;

  assign w_header   = {bus.rx_data[71:64], bus.rx_data[79:72],
                       bus.rx_data[87:80], bus.rx_data[95:88]};
  assign w_freq     = {bus.rx_data[39:32], bus.rx_data[47:40],
                       bus.rx_data[55:48], bus.rx_data[63:56]};
  assign w_setpoint = {bus.rx_data[23:16], bus.rx_data[31:24]};
  assign w_commit   = (r_state == ST_CHECK) && (w_header == RX_HEADER);
  assign w_unused   = &{1'b0, bus.rx_data[14:1]};

  logic [31:0] r_wd_cnt;
  logic        r_timeout;
  logic        r_frame_valid;
  logic [31:0] r_freq;
  logic [15:0] r_setpoint;
  logic        r_enable;
  logic        r_dout;

  // A commit takes priority over a watchdog expiry landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt      <= 32'd0;
      r_timeout     <= 1'b1;
      r_frame_valid <= 1'b0;
      r_freq        <= 32'd0;
      r_setpoint    <= 16'd0;
      r_enable      <= 1'b0;
      r_dout        <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_wd_cnt   <= 32'd0;
        r_timeout  <= 1'b0;
        r_freq     <= w_freq;
        r_setpoint <= w_setpoint;
        r_enable   <= bus.rx_data[15];
        r_dout     <= bus.rx_data[0];
      end else begin
        if (r_wd_cnt < WATCHDOG_CYCLES) r_wd_cnt <= r_wd_cnt + 32'd1;
        if (r_wd_cnt == WATCHDOG_CYCLES - 32'd1) begin
          r_timeout  <= 1'b1;
          r_freq     <= 32'd0;
          r_setpoint <= 16'd0;
          r_enable   <= 1'b0;
          r_dout     <= 1'b0;
        end
      end
    end
  end

  assign bus.frame_valid      = r_frame_valid;
  assign bus.jointFreqCmd0    = $signed(r_freq);
  assign bus.setPoint0        = r_setpoint;
  assign bus.jointEnable0     = r_enable;
  assign bus.DOUT0            = r_dout;
  assign bus.watchdog_timeout = r_timeout;

`ifdef SPI_RX_ERRCNT_EN
  logic       w_reject;
  logic [7:0] r_err_cnt;

  assign w_reject = (r_state == ST_CHECK) && (w_header != RX_HEADER);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_reject && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.error_count = r_err_cnt;
`else
  assign bus.error_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_rx_frame_decoder.sv
// Self-checking bench for spi_rx_frame_decoder: directed spec cases plus random frames
// compared every cycle against a byte-level frame/watchdog reference model.
module tb_spi_rx_frame_decoder;
  localparam int          WD  = 100;
  localparam logic [31:0] HDR = 32'h74697277;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b1;
  int   cyc   = 0;
  logic [1:0] w_dbg_state_unused;

  spi_rx_frame_decoder_if bus ();

  spi_rx_frame_decoder #(
    .RX_HEADER       (HDR),
    .WATCHDOG_CYCLES (32'(WD))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (w_dbg_state_unused)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] exp_q[$];      // {commit cycle, rx_data}
  bit           have_valid = 0;
  int           last_commit = 0;
  logic [31:0]  m_freq = '0;
  logic [15:0]  m_sp = '0;
  logic         m_en = 1'b0;
  logic         m_do = 1'b0;
  int           m_err = 0;
  int           n_good = 0;
  int           n_fv_obs = 0;
  logic [127:0] m_item;
  logic [95:0]  m_rx;
  logic         m_exp_fv;
  logic         m_exp_to;
  logic [7:0]   m_exp_err;

  function automatic logic [7:0] wire_byte(input logic [95:0] rx, input int i);
    return rx[95-8*i -: 8];
  endfunction

  function automatic logic [95:0] make_rx(input bit good);
    logic [95:0] rx;
    int          k;
    logic [7:0]  nz;
    rx        = {$urandom, $urandom, $urandom};
    rx[95:64] = {HDR[7:0], HDR[15:8], HDR[23:16], HDR[31:24]};
    if (!good) begin
      k  = $urandom_range(0, 3);
      nz = 8'($urandom_range(1, 255));
      rx[95-8*k -: 8] = rx[95-8*k -: 8] ^ nz;
    end
    return rx;
  endfunction

  always @(negedge clk) begin
    m_exp_fv = 1'b0;
    if (rst_q) begin
      have_valid = 0;
      m_err      = 0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0][127:96] == 32'(cyc)) begin
      m_item = exp_q.pop_front();
      m_rx   = m_item[95:0];
      if ({wire_byte(m_rx, 3), wire_byte(m_rx, 2), wire_byte(m_rx, 1), wire_byte(m_rx, 0)} == HDR) begin
        have_valid  = 1;
        last_commit = cyc;
        m_freq      = {wire_byte(m_rx, 7), wire_byte(m_rx, 6), wire_byte(m_rx, 5), wire_byte(m_rx, 4)};
        m_sp        = {wire_byte(m_rx, 9), wire_byte(m_rx, 8)};
        m_en        = wire_byte(m_rx, 10) >> 7;
        m_do        = wire_byte(m_rx, 11) & 8'h01;
        m_exp_fv    = 1'b1;
        n_good++;
      end else if (m_err < 255) begin
        m_err++;
      end
    end
    m_exp_to = !have_valid || (cyc - last_commit >= WD);
`ifdef SPI_RX_ERRCNT_EN
    m_exp_err = 8'(m_err);
`else
    m_exp_err = 8'd0;
`endif
    check("frame_valid", bus.frame_valid, m_exp_fv);
    check("watchdog_timeout", bus.watchdog_timeout, m_exp_to);
    check("jointFreqCmd0", $unsigned(bus.jointFreqCmd0), m_exp_to ? 32'd0 : m_freq);
    check("setPoint0", bus.setPoint0, m_exp_to ? 16'd0 : m_sp);
    check("jointEnable0", bus.jointEnable0, m_exp_to ? 1'b0 : m_en);
    check("DOUT0", bus.DOUT0, m_exp_to ? 1'b0 : m_do);
    check("error_count", bus.error_count, m_exp_err);
    if (bus.frame_valid === 1'b1) n_fv_obs++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [95:0] rx, input int low_c, input int high_c,
                            input bit expect_commit, output int commit_cyc);
    bus.SPI_SSEL = 1'b0;
    bus.rx_data  = rx;
    step(low_c);
    bus.SPI_SSEL = 1'b1;
    commit_cyc   = cyc + 6;
    if (expect_commit) exp_q.push_back({32'(commit_cyc), rx});
    step(high_c);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step(1);
  endtask

  // ---------------- stimulus ----------------
  logic [95:0] spec_rx;
  logic [95:0] bad_rx;
  logic [95:0] rx2;
  int          cc;
  int          e_commit;
  int          err_before;
  int          errcnt_en;

  initial begin
`ifdef SPI_RX_ERRCNT_EN
    errcnt_en = 1;
`else
    errcnt_en = 0;
`endif
    bus.SPI_SSEL = 1'b1;
    bus.rx_data  = '0;
    reset        = 1'b1;
    step(3);
    reset = 1'b0;
    step(10);
    @(negedge clk);
    check("rst_timeout", bus.watchdog_timeout, 1'b1);
    check("rst_freq", $unsigned(bus.jointFreqCmd0), 32'd0);
    step(1);

    // directed spec frame
    spec_rx = 96'h77726974_34120000_0201_8001;
    send_frame(spec_rx, 20, 10, 1'b1, cc);
    @(negedge clk);
    check("dir_freq", $unsigned(bus.jointFreqCmd0), 32'h00001234);
    check("dir_setpoint", bus.setPoint0, 16'h0102);
    check("dir_enable", bus.jointEnable0, 1'b1);
    check("dir_dout", bus.DOUT0, 1'b1);
    check("dir_timeout", bus.watchdog_timeout, 1'b0);
    step(1);

    // directed bad-header frame
    err_before     = int'(bus.error_count);
    bad_rx         = spec_rx;
    bad_rx[95:88]  = 8'h00;
    send_frame(bad_rx, 20, 10, 1'b1, cc);
    @(negedge clk);
    check("bad_freq_held", $unsigned(bus.jointFreqCmd0), 32'h00001234);
    check("bad_errcnt", bus.error_count, 8'(err_before + errcnt_en));
    step(1);

    // watchdog expiry then recovery
    step(WD + 10);
    @(negedge clk);
    check("wd_timeout", bus.watchdog_timeout, 1'b1);
    check("wd_freq_zero", $unsigned(bus.jointFreqCmd0), 32'd0);
    check("wd_setpoint_zero", bus.setPoint0, 16'd0);
    step(1);
    send_frame(spec_rx, 5, 10, 1'b1, e_commit);
    @(negedge clk);
    check("wd_restore_freq", $unsigned(bus.jointFreqCmd0), 32'h00001234);
    step(1);

    // commit landing exactly on the watchdog expiry edge
    rx2 = make_rx(1'b1);
    wait_until(e_commit + WD - 6 - 4);
    send_frame(rx2, 4, 10, 1'b1, cc);
    @(negedge clk);
    check("coincide_commit_cycle", 32'(cc), 32'(e_commit + WD));
    check("coincide_timeout", bus.watchdog_timeout, 1'b0);
    check("coincide_setpoint", bus.setPoint0, {wire_byte(rx2, 9), wire_byte(rx2, 8)});
    step(1);

    // reset in the middle of a transfer, then a clean transfer
    bus.SPI_SSEL = 1'b0;
    bus.rx_data  = spec_rx;
    step(5);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);
    bus.SPI_SSEL = 1'b1;
    step(15);
    @(negedge clk);
    check("midrst_errcnt", bus.error_count, 8'd0);
    check("midrst_timeout", bus.watchdog_timeout, 1'b1);
    step(1);
    send_frame(spec_rx, 6, 10, 1'b1, cc);

    // random frames, with occasional long idles around the watchdog boundary
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) step($urandom_range(WD - 8, WD + 8));
      send_frame(make_rx($urandom_range(0, 9) < 7), $urandom_range(1, 6),
                 $urandom_range(6, 12), 1'b1, cc);
    end

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      send_frame(make_rx(1'b0), 1, 6, 1'b1, cc);
    end
    step(2);
    @(negedge clk);
    check("errcnt_saturated", bus.error_count, errcnt_en ? 8'hFF : 8'h00);
    step(1);
    send_frame(spec_rx, 3, 10, 1'b1, cc);

    step(20);
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    check("frame_valid_count", 96'(n_fv_obs), 96'(n_good));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rx_frame_decoder.md
# spi_rx_frame_decoder

Downstream consumer of `interface_spislave`. It watches `SPI_SSEL` to detect the end of each SPI transfer, then validates the header of the 96-bit `rx_data` buffer and unpacks the byte-reversed fields into registered joint, vout and dout commands. A watchdog forces all outputs to a safe state when valid frames stop arriving.

## Interface
- `RX_HEADER`, default `32'h74697277`: required header value after byte reversal.
- `WATCHDOG_CYCLES`, default `32'd5000000`: clk cycles without a valid frame before timeout. Minimum 8.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `SPI_SSEL` in 1: raw chip select from the pin, active low, asynchronous to `clk`.
- `rx_data` in 96: receive buffer from `interface_spislave`. Stable from at least 1 clk after `SPI_SSEL` rises.
- `frame_valid` out 1: 1-cycle pulse when a valid frame is committed.
- `jointFreqCmd0` out 32 signed: joint frequency command.
- `setPoint0` out 16: vout setpoint.
- `jointEnable0` out 1: joint enable.
- `DOUT0` out 1: digital output.
- `watchdog_timeout` out 1: high while in the safe state.
- `error_count` out 8: saturating count of rejected frames.

## Operation
- `SPI_SSEL` passes through a 2-flop synchronizer (`ssel_s`), then a registered previous value (`ssel_d`).
  - `fall = ssel_d & ~ssel_s`
  - `rise = ~ssel_d & ssel_s`
- FSM states: IDLE, XFER, SETTLE, CHECK.
  - IDLE -> XFER on `fall`.
  - XFER -> SETTLE on `rise`.
  - SETTLE -> CHECK unconditionally (1 cycle).
  - CHECK -> IDLE unconditionally.
  - `fall` in SETTLE or CHECK is ignored. A frame that is already in progress when the block leaves reset is discarded, because IDLE requires a `fall` first.
- In CHECK, `rx_data` is decoded:
  - header = `{rx[71:64], rx[79:72], rx[87:80], rx[95:88]}`
  - freq = `{rx[39:32], rx[47:40], rx[55:48], rx[63:56]}`
  - setpoint = `{rx[23:16], rx[31:24]}`
  - enable = `rx[15]`
  - dout = `rx[0]`
- Header == `RX_HEADER`:
  - Register all four fields into the outputs.
  - Pulse `frame_valid`.
  - Reload the watchdog counter to 0.
  - Clear `watchdog_timeout`.
- Header mismatch:
  - Outputs unchanged.
  - `error_count` += 1, saturating at 255.
  - Watchdog not reloaded.
- Watchdog:
  - The counter increments every cycle while below `WATCHDOG_CYCLES`.
  - On reaching `WATCHDOG_CYCLES`, it sets `watchdog_timeout` and forces `jointFreqCmd0`, `setPoint0`, `jointEnable0` and `DOUT0` to 0 in the same cycle.
  - All four stay at 0 until the next valid frame.
- If watchdog expiry and a valid commit occur in the same cycle, the commit wins: new values are loaded, timeout is 0, and the counter is 0.
- Reset values:
  - FSM = IDLE; synchronizer flops = 1 (deasserted).
  - All command outputs 0; `frame_valid` 0; `error_count` 0; counter 0.
  - `watchdog_timeout` = 1, because no frame has been received yet.
- Reset asserted mid-frame aborts the frame with no commit and no error count.

## Timing
- Let the first clk edge that samples `SPI_SSEL` high be T0.
  - `ssel_s` high at T0+1; `rise` decoded in the T0+2 cycle.
  - SETTLE at T0+3, CHECK at T0+4.
  - Outputs and `frame_valid` are registered at T0+5.
- Total latency: 5 clk from SSEL rise to committed outputs.
- Minimum SSEL-high time for a frame to be accepted: 3 clk. Pulses shorter than the synchronizer can resolve may be missed; this is permitted.
- `error_count` updates at T0+5 on a mismatch.
- Back-to-back frames need at least 5 clk of SSEL high between transfers. A `fall` arriving during SETTLE/CHECK means that next transfer is not decoded.

## Configuration
- `SPI_RX_ERRCNT_EN` defined: the error counter is implemented as above.
- `SPI_RX_ERRCNT_EN` undefined:
  - `error_count` is tied to 8'd0 and no counter registers are synthesized.
  - Header mismatches are still rejected silently.

## Test plan
- Reset, no frames -> `watchdog_timeout`=1 and all outputs 0 after reset release.
- SSEL low for 20 cycles with `rx_data=96'h77726974_34120000_0201_8001`, then SSEL high -> 5 clk after T0: `frame_valid` pulses 1 cycle, `jointFreqCmd0=32'h00001234`, `setPoint0=16'h0102`, `jointEnable0=1`, `DOUT0=1`, `watchdog_timeout=0`.
- Same transfer with `rx[95:88]=8'h00` -> outputs keep their previous values, no `frame_valid`, `error_count` increments by 1. Run 300 bad frames -> `error_count` holds at 255.
- With `WATCHDOG_CYCLES=100`, one valid frame then idle -> 100 cycles later `watchdog_timeout`=1 and all command outputs 0. A next valid frame restores its values.
- Watchdog configured to expire in the commit cycle of a valid frame -> new values load and `watchdog_timeout`=0.
- `reset` pulsed while SSEL is low mid-transfer, followed by SSEL rise -> no `frame_valid` and no error increment. The next complete transfer decodes normally.
